// File: rtl/pipe_loop_ctrl_pkg.sv
// rtl/pipe_loop_ctrl_pkg.sv - shared types and helpers for the modulo-schedule loop controller
//
// Package pipe_loop_pkg:
//   state_t   - controller FSM state (IDLE, RUN, DONE)
//   ii_width  - width of the II-slot phase counter for a given initiation interval
package pipe_loop_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A phase counter always needs at least one bit, even when II == 1.
  function automatic int ii_width(input int ii);
    return (ii <= 1) ? 1 : $clog2(ii);
  endfunction

endpackage

// File: rtl/pipe_loop_ctrl_if.sv
// rtl/pipe_loop_ctrl_if.sv - start/finish handshake and schedule outputs of the loop controller
//
// Optional macro: PIPE_LOOP_CTRL_STALL_EN adds the stall request signal.
// Signals:
//   start       launch request (master -> controller)
//   trip_count  iteration count N, TRIP_W bits (master -> controller)
//   stall       freeze request, macro builds only (master -> controller)
//   busy        high while the loop runs (controller -> master)
//   ii_state    II-slot phase, II_W bits (controller -> master)
//   stage_valid per-stage live-iteration bits, NUM_STAGES bits (controller -> master)
//   stage_idx   per-stage iteration index, stage s at [s*TRIP_W +: TRIP_W] (controller -> master)
//   finish      one-cycle completion pulse (controller -> master)
// Modports: master = loop owner / datapath side, slave = the controller.
interface pipe_loop_ctrl_if #(
  parameter int II         = 3,
  parameter int NUM_STAGES = 3,
  parameter int TRIP_W     = 8
);
  import pipe_loop_pkg::*;

  localparam int II_W = ii_width(II);

  logic                         start;
  logic [TRIP_W-1:0]            trip_count;
`ifdef PIPE_LOOP_CTRL_STALL_EN
  logic                         stall;
`endif
  logic                         busy;
  logic [II_W-1:0]              ii_state;
  logic [NUM_STAGES-1:0]        stage_valid;
  logic [NUM_STAGES*TRIP_W-1:0] stage_idx;
  logic                         finish;

`ifdef PIPE_LOOP_CTRL_STALL_EN
  modport master (
    output start, trip_count, stall,
    input  busy, ii_state, stage_valid, stage_idx, finish
  );

  modport slave (
    input  start, trip_count, stall,
    output busy, ii_state, stage_valid, stage_idx, finish
  );
`else
  modport master (
    output start, trip_count,
    input  busy, ii_state, stage_valid, stage_idx, finish
  );

  modport slave (
    input  start, trip_count,
    output busy, ii_state, stage_valid, stage_idx, finish
  );
`endif

endinterface

// File: rtl/pipe_loop_ctrl_ii_counter.sv
// rtl/pipe_loop_ctrl_ii_counter.sv - II-slot phase counter with slot_end strobe
//
// Ports:
//   clk       in   clock
//   reset     in   synchronous active-high reset
//   run       in   count enable; counter is held at 0 while low
//   hold      in   freeze the phase (stall); also suppresses slot_end
//   ii_state  out  registered phase 0..II-1
//   slot_end  out  high in the last cycle of a slot (every run cycle when II == 1)
module pipe_loop_ii_counter #(
  parameter int II   = 3,
  parameter int II_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            hold,
  output logic [II_W-1:0] ii_state,
  output logic            slot_end
);

  localparam logic [II_W-1:0] LAST = II_W'(II - 1);

  assign slot_end = run && !hold && (ii_state == LAST);

  always_ff @(posedge clk) begin
    if (reset || !run) begin
      ii_state <= '0;
    end else if (slot_end) begin
      ii_state <= '0;
    end else if (!hold) begin
      ii_state <= ii_state + II_W'(1);
    end
  end

endmodule

// File: rtl/pipe_loop_ctrl.sv
// rtl/pipe_loop_ctrl.sv - modulo-schedule controller for hand-pipelined loops
//
// Optional macro: PIPE_LOOP_CTRL_STALL_EN (adds bus.stall; freezes the schedule in RUN).
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-high reset
//   bus    slave modport of pipe_loop_ctrl_if (start, trip_count, [stall] in;
//          busy, ii_state, stage_valid, stage_idx, finish out, all registered)
module pipe_loop_ctrl import pipe_loop_pkg::*; #(
  parameter int II         = 3,
  parameter int NUM_STAGES = 3,
  parameter int TRIP_W     = 8
) (
  input logic              clk,
  input logic              reset,
  pipe_loop_ctrl_if.slave  bus
);

  localparam int II_W = ii_width(II);

  state_t                               state;
  logic                                 busy_q;
  logic                                 finish_q;
  logic [NUM_STAGES-1:0]                valid_q;
  logic [NUM_STAGES-1:0]                valid_nxt;
  logic [NUM_STAGES-1:0][TRIP_W-1:0]    idx_q;
  logic [NUM_STAGES-1:0][TRIP_W-1:0]    idx_nxt;
  logic [TRIP_W-1:0]                    issued_q;
  logic [TRIP_W-1:0]                    trip_q;
  logic                                 issue;
  logic                                 hold;
  logic                                 slot_end;
  logic [II_W-1:0]                      ii_state;

`ifdef PIPE_LOOP_CTRL_STALL_EN
  assign hold = bus.stall;
`else
  assign hold = 1'b0;
`endif

  pipe_loop_ii_counter #(
    .II   (II),
    .II_W (II_W)
  ) u_ii_counter (
    .clk      (clk),
    .reset    (reset),
    .run      (state == RUN),
    .hold     (hold),
    .ii_state (ii_state),
    .slot_end (slot_end)
  );

  // Issue counter saturates at N, so once every iteration is out stage 0
  // keeps receiving a zero valid bit and the chain drains.
  assign issue = (issued_q < trip_q);

  always_comb begin
    valid_nxt    = '0;
    idx_nxt      = '0;
    valid_nxt[0] = issue;
    idx_nxt[0]   = issued_q;
    for (int s = 1; s < NUM_STAGES; s++) begin
      valid_nxt[s] = valid_q[s-1];
      idx_nxt[s]   = idx_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
      valid_q  <= '0;
      idx_q    <= '0;
      issued_q <= '0;
      trip_q   <= '0;
    end else begin
      finish_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            trip_q <= bus.trip_count;
            if (bus.trip_count == '0) begin
              state    <= DONE;
              finish_q <= 1'b1;
            end else begin
              // Iteration 0 enters stage 0 directly on acceptance.
              state    <= RUN;
              busy_q   <= 1'b1;
              valid_q  <= NUM_STAGES'(1);
              idx_q    <= '0;
              issued_q <= TRIP_W'(1);
            end
          end
        end
        RUN: begin
          // slot_end is already suppressed during stall, so everything holds.
          if (slot_end) begin
            valid_q <= valid_nxt;
            idx_q   <= idx_nxt;
            if (issue) begin
              issued_q <= issued_q + TRIP_W'(1);
            end
            // Last live iteration just left the final stage.
            if (valid_nxt == '0) begin
              state    <= DONE;
              busy_q   <= 1'b0;
              finish_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.finish      = finish_q;
  assign bus.ii_state    = ii_state;
  assign bus.stage_valid = valid_q;
  assign bus.stage_idx   = idx_q;

endmodule

// File: tb/tb_pipe_loop_ctrl.sv
// tb/tb_pipe_loop_ctrl.sv - self-checking bench for pipe_loop_ctrl
module tb_pipe_loop_ctrl;
  import pipe_loop_pkg::*;

  localparam int II = 3;
  localparam int NS = 3;
  localparam int TW = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pipe_loop_ctrl_if #(.II(II), .NUM_STAGES(NS), .TRIP_W(TW)) bus_a ();
  pipe_loop_ctrl_if #(.II(1),  .NUM_STAGES(1),  .TRIP_W(TW)) bus_b ();

  pipe_loop_ctrl #(.II(II), .NUM_STAGES(NS), .TRIP_W(TW)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  pipe_loop_ctrl #(.II(1), .NUM_STAGES(1), .TRIP_W(TW)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  // Advance one clock and settle just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_a.start      = 1'b0;
    bus_a.trip_count = '0;
    bus_b.start      = 1'b0;
    bus_b.trip_count = '0;
`ifdef PIPE_LOOP_CTRL_STALL_EN
    bus_a.stall = 1'b0;
    bus_b.stall = 1'b0;
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    cyc();
    cyc();
    reset = 1'b0;
    n_vec++;
    if (bus_a.busy !== 1'b0 || bus_a.finish !== 1'b0 || bus_a.ii_state !== '0 ||
        bus_a.stage_valid !== '0 || bus_a.stage_idx !== '0) begin
      n_err++;
      $display("FAIL reset_a: busy=%b fin=%b ii=%0d v=%b idx=%h, required all 0",
               bus_a.busy, bus_a.finish, bus_a.ii_state, bus_a.stage_valid, bus_a.stage_idx);
    end
    n_vec++;
    if (bus_b.busy !== 1'b0 || bus_b.finish !== 1'b0 || bus_b.ii_state !== '0 ||
        bus_b.stage_valid !== '0 || bus_b.stage_idx !== '0) begin
      n_err++;
      $display("FAIL reset_b: busy=%b fin=%b ii=%0d v=%b idx=%h, required all 0",
               bus_b.busy, bus_b.finish, bus_b.ii_state, bus_b.stage_valid, bus_b.stage_idx);
    end
    cyc();
  endtask

  // II=3, NS=3, N=4, start at cycle 0.
  task automatic test_schedule();
    logic exp_v0;
    bus_a.start = 1'b1;
    bus_a.trip_count = 8'd4;
    cyc();
    bus_a.start = 1'b0;
    bus_a.trip_count = 8'd200;  // changing N after acceptance must not matter
    for (int c = 1; c <= 24; c++) begin
      exp_v0 = (c >= 1 && c <= 12);
      n_vec++;
      if (bus_a.stage_valid[0] !== exp_v0) begin
        n_err++;
        $display("FAIL sched_v0 cycle %0d: got %b required %b", c, bus_a.stage_valid[0], exp_v0);
      end
      if (c >= 16 && c <= 18) begin
        n_vec++;
        if (bus_a.stage_valid[2] !== 1'b1 || bus_a.stage_idx[2*TW +: TW] !== 8'd3) begin
          n_err++;
          $display("FAIL sched_idx2 cycle %0d: got v=%b idx=%0d required v=1 idx=3",
                   c, bus_a.stage_valid[2], bus_a.stage_idx[2*TW +: TW]);
        end
      end
      n_vec++;
      if (bus_a.finish !== (c == 19) || bus_a.busy !== (c <= 18)) begin
        n_err++;
        $display("FAIL sched_fin cycle %0d: got fin=%b busy=%b required fin=%b busy=%b",
                 c, bus_a.finish, bus_a.busy, (c == 19), (c <= 18));
      end
      cyc();
    end
  endtask

  // Start re-pulsed mid-run and in DONE is ignored; start at cycle 20 runs again.
  task automatic test_back_to_back();
    logic exp_busy;
    bus_a.start = 1'b1;
    bus_a.trip_count = 8'd4;
    cyc();
    for (int c = 1; c <= 42; c++) begin
      bus_a.start = (c == 5 || c == 19 || c == 20);
      bus_a.trip_count = (c == 20) ? 8'd4 : 8'd9;
      exp_busy = (c >= 1 && c <= 18) || (c >= 21 && c <= 38);
      n_vec++;
      if (bus_a.finish !== (c == 19 || c == 39) || bus_a.busy !== exp_busy) begin
        n_err++;
        $display("FAIL b2b cycle %0d: got fin=%b busy=%b required fin=%b busy=%b",
                 c, bus_a.finish, bus_a.busy, (c == 19 || c == 39), exp_busy);
      end
      cyc();
    end
    bus_a.start = 1'b0;
  endtask

  task automatic test_zero_trip();
    bus_a.start = 1'b1;
    bus_a.trip_count = 8'd0;
    cyc();
    bus_a.start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      n_vec++;
      if (bus_a.finish !== (c == 1) || bus_a.busy !== 1'b0 || bus_a.stage_valid !== '0) begin
        n_err++;
        $display("FAIL zero_trip cycle %0d: got fin=%b busy=%b v=%b required fin=%b busy=0 v=0",
                 c, bus_a.finish, bus_a.busy, bus_a.stage_valid, (c == 1));
      end
      cyc();
    end
  endtask

  // II=1, NS=1, N=1 on the second instance.
  task automatic test_ii1();
    bus_b.start = 1'b1;
    bus_b.trip_count = 8'd1;
    cyc();
    bus_b.start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      n_vec++;
      if (bus_b.finish !== (c == 2) || bus_b.stage_valid[0] !== (c == 1) ||
          bus_b.busy !== (c == 1) || bus_b.ii_state !== 1'b0) begin
        n_err++;
        $display("FAIL ii1 cycle %0d: got fin=%b v=%b busy=%b ii=%0d required fin=%b v=%b busy=%b ii=0",
                 c, bus_b.finish, bus_b.stage_valid[0], bus_b.busy, bus_b.ii_state,
                 (c == 2), (c == 1), (c == 1));
      end
      cyc();
    end
  endtask

  task automatic test_reset_midrun();
    bus_a.start = 1'b1;
    bus_a.trip_count = 8'd4;
    cyc();
    bus_a.start = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      reset = (c == 8);
      if (c == 9) begin
        n_vec++;
        if (bus_a.busy !== 1'b0 || bus_a.finish !== 1'b0 || bus_a.ii_state !== '0 ||
            bus_a.stage_valid !== '0 || bus_a.stage_idx !== '0) begin
          n_err++;
          $display("FAIL midrun_reset: busy=%b fin=%b ii=%0d v=%b idx=%h, required all 0",
                   bus_a.busy, bus_a.finish, bus_a.ii_state, bus_a.stage_valid, bus_a.stage_idx);
        end
      end
      if (c > 9) begin
        n_vec++;
        if (bus_a.finish !== 1'b0 || bus_a.busy !== 1'b0) begin
          n_err++;
          $display("FAIL midrun_after cycle %0d: got fin=%b busy=%b required 0 0",
                   c, bus_a.finish, bus_a.busy);
        end
      end
      cyc();
    end
    reset = 1'b0;
  endtask

`ifdef PIPE_LOOP_CTRL_STALL_EN
  task automatic test_stall();
    logic [1:0] exp_ii;
    bus_a.start = 1'b1;
    bus_a.trip_count = 8'd4;
    cyc();
    bus_a.start = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      bus_a.stall = (c == 4 || c == 5);
      exp_ii = (c <= 4) ? 2'((c - 1) % 3) : (c <= 6) ? 2'd0 : 2'((c - 3) % 3);
      if (c <= 20) begin
        n_vec++;
        if (bus_a.ii_state !== exp_ii) begin
          n_err++;
          $display("FAIL stall_ii cycle %0d: got %0d required %0d", c, bus_a.ii_state, exp_ii);
        end
      end
      n_vec++;
      if (bus_a.finish !== (c == 21)) begin
        n_err++;
        $display("FAIL stall_fin cycle %0d: got %b required %b", c, bus_a.finish, (c == 21));
      end
      cyc();
    end
    bus_a.stall = 1'b0;
  endtask
`endif

  // Random start/trip/stall/reset traffic against a schedule model built from
  // the timing rules: e = unstalled RUN cycles since acceptance, slot = e / II,
  // stage s holds iteration slot - s, and finish lands at e == (N + NS - 1) * II.
  task automatic test_random();
    bit         m_run, m_done, r, s, st;
    int         m_n, m_e, m_len, t, k;
    logic       e_busy, e_fin, e_v;
    logic [1:0] e_ii;
    m_run = 0; m_done = 0; m_n = 0; m_e = 0; m_len = 0;
    reset = 1'b1;
    idle_inputs();
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      r  = ($urandom_range(149) == 0);
      s  = ($urandom_range(3) == 0);
      t  = $urandom_range(7);
      st = 1'b0;
`ifdef PIPE_LOOP_CTRL_STALL_EN
      st = ($urandom_range(4) == 0);
      bus_a.stall = st;
`endif
      reset            = r;
      bus_a.start      = s;
      bus_a.trip_count = TW'(t);
      cyc();
      if (r) begin
        m_run = 0; m_done = 0;
      end else if (m_done) begin
        m_done = 0;
      end else if (m_run) begin
        if (!st) m_e++;
        if (m_e == m_len) begin
          m_run = 0; m_done = 1;
        end
      end else if (s) begin
        if (t == 0) m_done = 1;
        else begin
          m_run = 1; m_e = 0; m_n = t; m_len = (t + NS - 1) * II;
        end
      end
      e_busy = m_run;
      e_fin  = m_done;
      e_ii   = m_run ? 2'(m_e % II) : 2'd0;
      n_vec++;
      if (bus_a.busy !== e_busy || bus_a.finish !== e_fin || bus_a.ii_state !== e_ii) begin
        n_err++;
        $display("FAIL rand_ctl step %0d: got busy=%b fin=%b ii=%0d required busy=%b fin=%b ii=%0d",
                 i, bus_a.busy, bus_a.finish, bus_a.ii_state, e_busy, e_fin, e_ii);
      end
      for (int g = 0; g < NS; g++) begin
        k   = m_e / II - g;
        e_v = m_run && (k >= 0) && (k < m_n);
        n_vec++;
        if (bus_a.stage_valid[g] !== e_v || (e_v && bus_a.stage_idx[g*TW +: TW] !== TW'(k))) begin
          n_err++;
          $display("FAIL rand_stage%0d step %0d: got v=%b idx=%0d required v=%b idx=%0d",
                   g, i, bus_a.stage_valid[g], bus_a.stage_idx[g*TW +: TW], e_v, k);
        end
      end
    end
    reset = 1'b0;
    idle_inputs();
    cyc();
    cyc();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_schedule();
    test_back_to_back();
    test_zero_trip();
    test_ii1();
    test_reset_midrun();
`ifdef PIPE_LOOP_CTRL_STALL_EN
    test_stall();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_loop_ctrl.md
# pipe_loop_ctrl

Modulo-schedule controller for hand-pipelined loops built on single-port RAM datapaths. It turns a `start` pulse and a trip count into the signals the datapath needs: II-slot phase, per-stage valid bits, per-stage iteration indices, and a one-cycle `finish`. It sits between the top-level start/finish handshake and the loop datapath, replacing ad-hoc valid-bit chains and epilogue flags.

## Interface
- `II`, default 3: initiation interval in cycles, ≥1.
- `NUM_STAGES`, default 3: pipeline depth in II-slots, ≥1.
- `TRIP_W`, default 8: width of trip count and iteration indices.
- `clk`  in  1  clock; reset reset, synchronous, active-high; clock clk.
- `reset`  in  1  synchronous active-high reset.
- `start`  in  1  launch request; sampled only in IDLE.
- `trip_count`  in  TRIP_W  iteration count N; latched when `start` is accepted.
- `busy`  out  1  high in RUN.
- `ii_state`  out  II_W  slot phase 0..II-1, where II_W = 1 if II == 1, else clog2(II).
- `stage_valid`  out  NUM_STAGES  bit s: stage s holds a live iteration this slot.
- `stage_idx`  out  NUM_STAGES*TRIP_W  iteration index of stage s at `[s*TRIP_W +: TRIP_W]`.
- `finish`  out  1  one-cycle completion pulse.
- `stall`  in  1  freeze request; present only with the macro defined.

## Operation
- FSM states and transitions:
  - IDLE → RUN on `start`.
  - IDLE → DONE on `start` with N == 0.
  - RUN → DONE after the slot in which the last valid bit leaves stage NUM_STAGES-1.
  - DONE → IDLE unconditionally.
- Reset values: state IDLE, `ii_state` 0, `stage_valid` 0, `stage_idx` 0, issue counter 0, `busy` 0, `finish` 0.
- Phase counter: in RUN, `ii_state` counts 0..II-1 and wraps. In IDLE and DONE it is held at 0.
- Slot boundary: the wrap from II-1 to 0, or every cycle when II == 1. At each boundary:
  - `stage_valid[s]` ← `stage_valid[s-1]`; `stage_idx[s]` ← `stage_idx[s-1]`.
  - `stage_valid[0]` ← (issued < N); `stage_idx[0]` ← issued.
  - The issue counter increments when an iteration is issued.
- Accept cycle: on accepting `start`, load `stage_valid[0]` = 1 and `stage_idx[0]` = 0; the issue counter becomes 1.
- Arithmetic: the issue counter is TRIP_W bits and saturates at N. Indices run 0..N-1; no wrap is possible because N ≤ 2^TRIP_W-1.
- `start` outside IDLE, including in the DONE cycle, is ignored; no queuing.
- Reset mid-operation returns everything to reset values next cycle; no `finish` is produced.
- `trip_count` changes after acceptance have no effect.

## Timing
- `start` accepted at cycle T, N ≥ 1:
  - RUN from T+1.
  - Iteration k occupies stage s during cycles T+1+(k+s)·II … T+(k+s+1)·II.
  - `finish` = 1 exactly at cycle T+1+(N+NUM_STAGES-1)·II; state DONE, all valids 0, `busy` 0.
  - Next `start` can be accepted at cycle T+2+(N+NUM_STAGES-1)·II.
- N == 0: `finish` at T+1; no valid bit ever set.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `PIPE_LOOP_CTRL_STALL_EN` defined: adds the `stall` port. When `stall` = 1 in RUN, the phase counter, FSM, valids, indices and issue counter all hold. `finish` and every later event are delayed by the number of stalled cycles. `stall` is ignored in IDLE and DONE.
- Not defined: no `stall` port; the schedule never freezes.

## Structure
- Package `pipe_loop_pkg` holds:
  - the FSM state typedef (IDLE, RUN, DONE);
  - the II_W width function.
- Natural sub-module: `pipe_loop_ii_counter`. It is the phase counter that emits `ii_state` and a `slot_end` strobe, with a hold input for the stall macro.
- The valid/index shift chain and the FSM live in `pipe_loop_ctrl`.

## Test plan
- II=3, NUM_STAGES=3, N=4, `start` at cycle 0:
  - `stage_valid[0]` high cycles 1–12.
  - `stage_idx[2]` = 3 during cycles 16–18.
  - `finish` high at cycle 19 only.
- N=0: `finish` at cycle 1, `busy` never high, `stage_valid` stays 0.
- II=1, NUM_STAGES=1, N=1: `finish` at cycle 2; `stage_valid[0]` high at cycle 1 only.
- `start` re-pulsed at cycle 5 of an N=4 run: ignored, and `finish` is still at 19. A second `start` at cycle 20 runs normally, with `finish` at 39.
- `reset` at cycle 8 of a run: next cycle all outputs are 0 and state is IDLE; `finish` never pulses.
- With `PIPE_LOOP_CTRL_STALL_EN`, `stall` high cycles 4–5: `ii_state` frozen on those cycles and `finish` at cycle 21.
